// File: rtl/gpr_wb_pkg.sv
// Shared types and constants for the GPR write-back arbiter.
package gpr_wb_pkg;

    typedef enum logic [0:0] {
        NORMAL,
        FORCE
    } wb_state_e;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_req_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/wb_fifo.sv
// Circular FIFO of write-back requests; every slot is exposed with a valid bit so the
// parent can search queued destinations.
module wb_fifo
    import gpr_wb_pkg::*;
#(
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  wb_req_t         push_data_i,
    input  logic            pop_i,
    output wb_req_t         pop_data_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o,
    output wb_req_t         entries_o [Depth],
    output logic [Depth-1:0] valid_o
);

    wb_req_t         mem_q [Depth];
    wb_req_t         mem_d [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_data_i;
            wr_ptr_d        = wr_ptr_q + PtrW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + CntW'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Slot i is live when its distance from the read pointer is below the occupancy.
    for (genvar i = 0; i < Depth; i++) begin : g_valid
        assign valid_o[i] = {1'b0, PtrW'(PtrW'(i) - rd_ptr_q)} < count_q;
    end

    assign entries_o  = mem_q;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = (count_q == CntW'(Depth));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

endmodule

// File: rtl/gpr_wb_arbiter.sv
// Single-port GPR write-back arbiter: pipeline has priority, long-latency unit is queued,
// and a starvation limit forces FIFO grants. Define GPR_WB_TRACE_EN for commit tracing.
module gpr_wb_arbiter
    import gpr_wb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 3,
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            p_valid,
    input  logic [4:0]      p_addr,
    input  logic [31:0]     p_data,
    output logic            p_ready,
    input  logic            m_valid,
    input  logic [4:0]      m_addr,
    input  logic [31:0]     m_data,
    output logic            m_ready,
    input  logic [4:0]      q_addr,
    output logic            q_pending,
    output logic [CntW-1:0] fifo_count,
    output logic            RegWrite,
    output logic [4:0]      RegAddr,
    output logic [31:0]     RegData
);

    wb_state_e       state_q, state_d;
    logic [3:0]      starve_q, starve_d;
    wb_req_t         wb_q, wb_d;
    logic            we_q, we_d;
    logic            grant_p, grant_f;
    logic            fifo_full, fifo_empty;
    wb_req_t         m_req, head;
    wb_req_t         entries [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] entry_valid;

    assign m_req   = '{addr: m_addr, data: m_data};
    assign m_ready = !fifo_full;

    wb_fifo #(
        .Depth (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (m_valid && !fifo_full),
        .push_data_i (m_req),
        .pop_i       (grant_f),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .entries_o   (entries),
        .valid_o     (entry_valid)
    );

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        grant_p  = 1'b0;
        grant_f  = 1'b0;
        p_ready  = 1'b0;
        unique case (state_q)
            NORMAL: begin
                p_ready = 1'b1;
                if (p_valid) begin
                    grant_p = 1'b1;
                    if (!fifo_empty) begin
                        starve_d = starve_q + 4'd1;
                        if (starve_d == 4'(STARVE_LIMIT)) begin
                            state_d = FORCE;
                        end
                    end else begin
                        starve_d = '0;
                    end
                end else begin
                    grant_f  = !fifo_empty;
                    starve_d = '0;
                end
            end
            FORCE: begin
                // Entry into FORCE implies the FIFO was non-empty and nothing else pops it.
                grant_f  = 1'b1;
                starve_d = '0;
                state_d  = NORMAL;
            end
            default: state_d = NORMAL;
        endcase
    end

    always_comb begin
        wb_d = wb_q;
        we_d = 1'b0;
        if (grant_p) begin
            wb_d = '{addr: p_addr, data: p_data};
            we_d = (p_addr != REG_ZERO);
        end else if (grant_f) begin
            wb_d = head;
            we_d = (head.addr != REG_ZERO);
        end
    end

    always_comb begin
        q_pending = we_q && (wb_q.addr == q_addr);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i] && (entries[i].addr == q_addr)) begin
                q_pending = 1'b1;
            end
        end
        if (q_addr == REG_ZERO) begin
            q_pending = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= NORMAL;
            starve_q <= '0;
            wb_q     <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            wb_q     <= wb_d;
            we_q     <= we_d;
        end
    end

    assign RegWrite = we_q;
    assign RegAddr  = wb_q.addr;
    assign RegData  = wb_q.data;

`ifdef GPR_WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && we_d) begin
            $display("$%0d <= %08h", wb_d.addr, wb_d.data);
        end
        if (!reset && state_q == NORMAL && state_d == FORCE) begin
            $display("gpr_wb_arbiter: entering FORCE, FIFO head granted next");
        end
    end
`else
    // Trace output compiled out.
`endif

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Self-checking bench for gpr_wb_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_gpr_wb_arbiter;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_valid, m_valid, p_ready, m_ready, q_pending, RegWrite;
    logic [4:0]  p_addr, m_addr, q_addr, RegAddr;
    logic [31:0] p_data, m_data, RegData;
    logic [2:0]  fifo_count;

    int checks   = 0;
    int failures = 0;

    gpr_wb_arbiter #(
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .p_valid    (p_valid),
        .p_addr     (p_addr),
        .p_data     (p_data),
        .p_ready    (p_ready),
        .m_valid    (m_valid),
        .m_addr     (m_addr),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .q_addr     (q_addr),
        .q_pending  (q_pending),
        .fifo_count (fifo_count),
        .RegWrite   (RegWrite),
        .RegAddr    (RegAddr),
        .RegData    (RegData)
    );

    always #5 clk = ~clk;

    task automatic drive_idle();
        p_valid = 1'b0; p_addr = '0; p_data = '0;
        m_valid = 1'b0; m_addr = '0; m_data = '0;
        q_addr  = '0;
    endtask

    // Leaves the bench at a falling edge with reset just released.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
        checks++; if (m_ready !== 1'b1) begin failures++; $display("FAIL reset_m_ready got=%b exp=1", m_ready); end
        checks++; if (p_ready !== 1'b1) begin failures++; $display("FAIL reset_p_ready got=%b exp=1", p_ready); end
        checks++; if (q_pending !== 1'b0) begin failures++; $display("FAIL reset_q_pending got=%b exp=0", q_pending); end
        checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL reset_regwrite got=%b exp=0", RegWrite); end
        checks++; if (RegAddr !== 5'd0) begin failures++; $display("FAIL reset_regaddr got=%0d exp=0", RegAddr); end
        checks++; if (RegData !== 32'd0) begin failures++; $display("FAIL reset_regdata got=%h exp=0", RegData); end
    endtask

    task automatic test_pipeline();
        do_reset();
        p_valid = 1'b1; p_addr = 5'd5; p_data = 32'h1234;
        #1;
        checks++; if (p_ready !== 1'b1) begin failures++; $display("FAIL pipe_p_ready got=%b exp=1", p_ready); end
        @(negedge clk);
        p_valid = 1'b0;
        #1;
        checks++; if (RegWrite !== 1'b1) begin failures++; $display("FAIL pipe_regwrite got=%b exp=1", RegWrite); end
        checks++; if (RegAddr !== 5'd5) begin failures++; $display("FAIL pipe_regaddr got=%0d exp=5", RegAddr); end
        checks++; if (RegData !== 32'h1234) begin failures++; $display("FAIL pipe_regdata got=%h exp=1234", RegData); end
        checks++; if (fifo_count !== 3'd0) begin failures++; $display("FAIL pipe_count got=%0d exp=0", fifo_count); end
        @(negedge clk);
        #1;
        checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL idle_regwrite got=%b exp=0", RegWrite); end
        checks++; if (RegAddr !== 5'd5 || RegData !== 32'h1234) begin
            failures++; $display("FAIL idle_hold got=%0d/%h exp=5/1234", RegAddr, RegData);
        end
    endtask

    task automatic test_fifo_latency();
        do_reset();
        m_valid = 1'b1; m_addr = 5'd8; m_data = 32'hAAAA; q_addr = 5'd8;
        #1;
        checks++; if (m_ready !== 1'b1) begin failures++; $display("FAIL lat_m_ready got=%b exp=1", m_ready); end
        checks++; if (q_pending !== 1'b0) begin failures++; $display("FAIL lat_pend0 got=%b exp=0", q_pending); end
        @(negedge clk);
        m_valid = 1'b0;
        #1;
        checks++; if (q_pending !== 1'b1) begin failures++; $display("FAIL lat_pend1 got=%b exp=1", q_pending); end
        checks++; if (fifo_count !== 3'd1) begin failures++; $display("FAIL lat_count got=%0d exp=1", fifo_count); end
        checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL lat_no_bypass got=%b exp=0", RegWrite); end
        @(negedge clk);
        #1;
        checks++; if (q_pending !== 1'b1) begin failures++; $display("FAIL lat_pend2 got=%b exp=1", q_pending); end
        checks++; if (RegWrite !== 1'b1 || RegAddr !== 5'd8 || RegData !== 32'hAAAA) begin
            failures++; $display("FAIL lat_commit got=%b/%0d/%h exp=1/8/aaaa", RegWrite, RegAddr, RegData);
        end
        @(negedge clk);
        #1;
        checks++; if (q_pending !== 1'b0) begin failures++; $display("FAIL lat_pend3 got=%b exp=0", q_pending); end
    endtask

    task automatic test_starve();
        logic [4:0]  exp_a;
        logic [31:0] exp_d;
        do_reset();
        m_valid = 1'b1; m_addr = 5'd9; m_data = 32'h99;
        @(negedge clk);
        m_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            p_valid = 1'b1; p_addr = 5'(10 + k); p_data = 32'h500 + 32'(k);
            #1;
            checks++; if (p_ready !== (k != 3)) begin
                failures++; $display("FAIL starve_p_ready[%0d] got=%b exp=%b", k, p_ready, k != 3);
            end
            if (k >= 1) begin
                exp_a = (k == 4) ? 5'd9 : 5'(10 + k - 1);
                exp_d = (k == 4) ? 32'h99 : 32'h500 + 32'(k - 1);
                checks++; if (RegWrite !== 1'b1 || RegAddr !== exp_a || RegData !== exp_d) begin
                    failures++;
                    $display("FAIL starve_commit[%0d] got=%b/%0d/%h exp=1/%0d/%h",
                             k, RegWrite, RegAddr, RegData, exp_a, exp_d);
                end
            end
            @(negedge clk);
        end
        p_valid = 1'b0;
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            m_valid = (k < 5); m_addr = 5'(16 + k); m_data = 32'(k);
            p_valid = (k < 5); p_addr = 5'd1; p_data = 32'h100 + 32'(k);
            #1;
            if (k < 5) begin
                checks++; if (m_ready !== (k < 4)) begin
                    failures++; $display("FAIL full_m_ready[%0d] got=%b exp=%b", k, m_ready, k < 4);
                end
                checks++; if (fifo_count !== 3'(k)) begin
                    failures++; $display("FAIL full_count[%0d] got=%0d exp=%0d", k, fifo_count, k);
                end
            end else if (k < 9) begin
                checks++; if (RegWrite !== 1'b1 || RegAddr !== 5'(11 + k) || RegData !== 32'(k - 5)
                              || fifo_count !== 3'(8 - k)) begin
                    failures++;
                    $display("FAIL drain[%0d] got=%b/%0d/%h cnt=%0d exp=1/%0d/%h cnt=%0d", k, RegWrite,
                             RegAddr, RegData, fifo_count, 11 + k, k - 5, 8 - k);
                end
            end else begin
                checks++; if (RegWrite !== 1'b0) begin
                    failures++; $display("FAIL full_refused_entry got=%b exp=0", RegWrite);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_zero_addr();
        do_reset();
        p_valid = 1'b1; p_addr = 5'd0; p_data = 32'hFFFF; q_addr = 5'd0;
        #1;
        checks++; if (p_ready !== 1'b1) begin failures++; $display("FAIL zero_p_ready got=%b exp=1", p_ready); end
        @(negedge clk);
        p_valid = 1'b0;
        #1;
        checks++; if (RegWrite !== 1'b0) begin failures++; $display("FAIL zero_regwrite got=%b exp=0", RegWrite); end
        checks++; if (q_pending !== 1'b0) begin failures++; $display("FAIL zero_q_pending got=%b exp=0", q_pending); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            m_valid = 1'b1; m_addr = 5'(20 + k); m_data = 32'(k + 1);
            p_valid = 1'b1; p_addr = 5'd2; p_data = 32'h22;
            @(negedge clk);
        end
        drive_idle();
        #1;
        checks++; if (fifo_count !== 3'd3) begin failures++; $display("FAIL mid_pre_count got=%0d exp=3", fifo_count); end
        reset = 1'b1;
        #1;
        checks++; if (fifo_count !== 3'd0 || RegWrite !== 1'b0 || m_ready !== 1'b1) begin
            failures++; $display("FAIL mid_reset got=cnt%0d/we%b/mr%b exp=cnt0/we0/mr1",
                                 fifo_count, RegWrite, m_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (RegWrite !== 1'b0 || fifo_count !== 3'd0) begin
                failures++; $display("FAIL mid_after[%0d] got=we%b/cnt%0d exp=we0/cnt0", k, RegWrite, fifo_count);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [4:0]  qa [$];
        logic [31:0] qd [$];
        int          streak;
        bit          force_next, e_we, exp_pend, mr, granted;
        logic [4:0]  e_addr, ga;
        logic [31:0] e_data, gd;
        streak = 0; force_next = 0; e_we = 0; e_addr = '0; e_data = '0;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            p_valid = ($urandom_range(0, 1) == 1);
            p_addr  = 5'($urandom_range(0, 7));
            p_data  = $urandom;
            m_valid = ($urandom_range(0, 9) < 6);
            m_addr  = 5'($urandom_range(0, 7));
            m_data  = $urandom;
            q_addr  = 5'($urandom_range(0, 7));
            #1;
            exp_pend = 0;
            if (q_addr != 0) begin
                if (e_we && e_addr == q_addr) exp_pend = 1;
                foreach (qa[j]) if (qa[j] == q_addr) exp_pend = 1;
            end
            mr = (qa.size() < DEPTH);
            checks++; if (p_ready !== !force_next) begin
                failures++; $display("FAIL rnd_p_ready[%0d] got=%b exp=%b", cyc, p_ready, !force_next);
            end
            checks++; if (m_ready !== mr) begin
                failures++; $display("FAIL rnd_m_ready[%0d] got=%b exp=%b", cyc, m_ready, mr);
            end
            checks++; if (fifo_count !== 3'(qa.size())) begin
                failures++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", cyc, fifo_count, qa.size());
            end
            checks++; if (q_pending !== exp_pend) begin
                failures++; $display("FAIL rnd_q_pending[%0d] q=%0d got=%b exp=%b", cyc, q_addr, q_pending, exp_pend);
            end
            checks++; if (RegWrite !== e_we) begin
                failures++; $display("FAIL rnd_regwrite[%0d] got=%b exp=%b", cyc, RegWrite, e_we);
            end
            checks++; if (RegAddr !== e_addr || RegData !== e_data) begin
                failures++; $display("FAIL rnd_regout[%0d] got=%0d/%h exp=%0d/%h", cyc, RegAddr, RegData, e_addr, e_data);
            end
            granted = 0; ga = '0; gd = '0;
            if (force_next) begin
                ga = qa.pop_front(); gd = qd.pop_front(); granted = 1;
                streak = 0; force_next = 0;
            end else if (p_valid) begin
                ga = p_addr; gd = p_data; granted = 1;
                if (qa.size() > 0) begin
                    streak++;
                    if (streak == LIMIT) force_next = 1;
                end else begin
                    streak = 0;
                end
            end else if (qa.size() > 0) begin
                ga = qa.pop_front(); gd = qd.pop_front(); granted = 1;
                streak = 0;
            end else begin
                streak = 0;
            end
            if (m_valid && mr) begin
                qa.push_back(m_addr); qd.push_back(m_data);
            end
            if (granted) begin
                e_we = (ga != 0); e_addr = ga; e_data = gd;
            end else begin
                e_we = 0;
            end
            @(negedge clk);
        end
        drive_idle();
    endtask

    initial begin
        reset = 1'b1;
        drive_idle();
        test_reset();
        test_pipeline();
        test_fifo_latency();
        test_starve();
        test_full();
        test_zero_addr();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
